inst_rom_port_arbiter: RTL and testbench

- Shares the single instruction-ROM read port between two requesters: the IF-stage fetch (port "if", high priority) and the branch-predictor lookahead (port "pdt", low priority).
- Sequences each ROM access over a parameterised wait window and registers the returned word.
- Applies starvation protection so the predictor is eventually served.
- Supports flush-cancellation of an in-flight IF fetch.
- Sits between the IF stage, the predictor and the ROM.

---
 rtl/inst_rom_port_arbiter_if.sv | 41 ++++
 rtl/inst_rom_port_arbiter.sv | 126 ++++++++++++
 tb/tb_inst_rom_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_port_arbiter_if.sv
// inst_rom_port_arbiter_if
// Bundles the two requester channels (IF fetch, predictor lookahead) and the
// instruction-ROM read port that the arbiter multiplexes between them.
//   if_*  : IF fetch request/grant/response channel (high priority)
//   pdt_* : branch-predictor lookahead channel (low priority)
//   rom_* : ROM chip enable, byte address and returned word
// Modports:
//   master : requesters and ROM side (drive requests and rom_inst)
//   slave  : the arbiter itself
interface inst_rom_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_rerr;

  logic        pdt_req;
  logic [31:0] pdt_addr;
  logic        pdt_gnt;
  logic        pdt_rvalid;
  logic [31:0] pdt_rdata;
  logic        pdt_rerr;

  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  modport master (
    output if_req, if_addr, if_flush, pdt_req, pdt_addr, rom_inst,
    input  if_gnt, if_rvalid, if_rdata, if_rerr,
           pdt_gnt, pdt_rvalid, pdt_rdata, pdt_rerr, rom_ce, rom_addr
  );

  modport slave (
    input  if_req, if_addr, if_flush, pdt_req, pdt_addr, rom_inst,
    output if_gnt, if_rvalid, if_rdata, if_rerr,
           pdt_gnt, pdt_rvalid, pdt_rdata, pdt_rerr, rom_ce, rom_addr
  );
endinterface

// File: rtl/inst_rom_port_arbiter.sv
// inst_rom_port_arbiter
// Shares the single instruction-ROM read port between the IF fetch (high
// priority) and the branch-predictor lookahead (low priority). Each access
// holds rom_ce/rom_addr for ROM_WAIT cycles, captures rom_inst on the last
// one, then presents a one-cycle response. Misaligned addresses skip the ROM
// and respond next cycle with rerr. A starvation counter forces a predictor
// grant after STARVE_MAX consecutive IF wins, and if_flush cancels the
// response of an in-flight IF access without disturbing ROM timing.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : requester/ROM bundle (slave modport)
//   busy : high while a ROM access is in progress
module inst_rom_port_arbiter #(
  parameter int ROM_WAIT   = 1,  // 1..15
  parameter int STARVE_MAX = 3   // 1..15
) (
  input  logic                    clk,
  input  logic                    rst,
  inst_rom_port_arbiter_if.slave  bus,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic       OWN_IF    = 1'b0;
  localparam logic       OWN_PDT   = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(ROM_WAIT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [3:0]  wait_q;
  logic [3:0]  starve_q;
  logic        owner_q;
  logic [31:0] addr_q;
  logic        cancel_q;
  logic [31:0] if_rdata_q, pdt_rdata_q;
  logic        if_rerr_q, pdt_rerr_q;

  logic        gnt_if, gnt_pdt, gnt_any, gnt_misal, capture;
  logic [31:0] gnt_addr;

  // Grant and next-state decode. A new grant may overlap the RESP cycle of
  // the previous access, giving one access every ROM_WAIT+1 cycles.
  always_comb begin
    gnt_if    = 1'b0;
    gnt_pdt   = 1'b0;
    gnt_addr  = bus.if_addr;
    gnt_misal = 1'b0;
    capture   = 1'b0;
    state_d   = state_q;

    if (state_q != BUSY) begin
      gnt_if  = bus.if_req && !(bus.pdt_req && starve_q == STARVE_LIM);
      gnt_pdt = bus.pdt_req && !gnt_if;
    end
    gnt_any   = gnt_if || gnt_pdt;
    if (gnt_pdt) gnt_addr = bus.pdt_addr;
    gnt_misal = gnt_addr[1:0] != 2'b00;
    capture   = (state_q == BUSY) && (wait_q == 4'd1);

    case (state_q)
      IDLE, RESP: begin
        if (gnt_any) state_d = gnt_misal ? RESP : BUSY;
        else         state_d = IDLE;
      end
      BUSY:    state_d = capture ? RESP : BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      cancel_q    <= 1'b0;
      if_rdata_q  <= '0;
      pdt_rdata_q <= '0;
      if_rerr_q   <= 1'b0;
      pdt_rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (gnt_any) begin
        owner_q  <= gnt_pdt ? OWN_PDT : OWN_IF;
        addr_q   <= gnt_addr;
        wait_q   <= WAIT_INIT;
        // A fresh grant starts uncancelled even if if_flush is high now.
        cancel_q <= 1'b0;
        if (gnt_misal) begin
          if (gnt_pdt) begin pdt_rdata_q <= '0; pdt_rerr_q <= 1'b1; end
          else         begin if_rdata_q  <= '0; if_rerr_q  <= 1'b1; end
        end
      end else begin
        if (state_q == BUSY) wait_q <= wait_q - 4'd1;
        if (capture) begin
          if (owner_q == OWN_PDT) begin pdt_rdata_q <= bus.rom_inst; pdt_rerr_q <= 1'b0; end
          else                    begin if_rdata_q  <= bus.rom_inst; if_rerr_q  <= 1'b0; end
        end
        if (bus.if_flush && owner_q == OWN_IF && state_q != IDLE) cancel_q <= 1'b1;
      end

      if (gnt_pdt)
        starve_q <= '0;
      else if (gnt_if && bus.pdt_req && starve_q != STARVE_LIM)
        starve_q <= starve_q + 4'd1;
    end
  end

  assign bus.if_gnt     = gnt_if;
  assign bus.pdt_gnt    = gnt_pdt;
  // Flush seen during the RESP cycle itself must also kill that strobe,
  // hence the direct if_flush term alongside the registered cancel flag.
  assign bus.if_rvalid  = (state_q == RESP) && (owner_q == OWN_IF) &&
                          !cancel_q && !bus.if_flush;
  assign bus.pdt_rvalid = (state_q == RESP) && (owner_q == OWN_PDT);
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_rerr    = if_rerr_q;
  assign bus.pdt_rdata  = pdt_rdata_q;
  assign bus.pdt_rerr   = pdt_rerr_q;
  assign bus.rom_ce     = (state_q == BUSY);
  assign bus.rom_addr   = addr_q;
  assign busy           = (state_q == BUSY);
endmodule

// File: tb/tb_inst_rom_port_arbiter.sv
module tb_inst_rom_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  inst_rom_port_arbiter_if b1();
  inst_rom_port_arbiter_if b3();
  logic busy1, busy3;

  inst_rom_port_arbiter #(.ROM_WAIT(1), .STARVE_MAX(3)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1));
  inst_rom_port_arbiter #(.ROM_WAIT(3), .STARVE_MAX(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave), .busy(busy3));

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h3401_0020;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // ROM model: garbage whenever the chip is disabled.
  assign b1.rom_inst = b1.rom_ce ? rom_word(b1.rom_addr) : 32'hDEAD_BEEF;
  assign b3.rom_inst = b3.rom_ce ? rom_word(b3.rom_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        port;  // 0 = if, 1 = pdt
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard consumers: every response strobe pops the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (b1.if_rvalid || b1.pdt_rvalid) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL w1_unexpected_resp if_rv=%0b pdt_rv=%0b cyc=%0d required none",
                 b1.if_rvalid, b1.pdt_rvalid, cyc);
      end else begin
        e = q1.pop_front();
        if (b1.pdt_rvalid !== e.port || b1.if_rvalid === b1.pdt_rvalid ||
            (e.port ? b1.pdt_rdata : b1.if_rdata) !== e.data ||
            (e.port ? b1.pdt_rerr : b1.if_rerr) !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL w1_resp port=%0b data=%h err=%0b cyc=%0d required port=%0b data=%h err=%0b cyc=%0d",
                   b1.pdt_rvalid, b1.pdt_rvalid ? b1.pdt_rdata : b1.if_rdata,
                   b1.pdt_rvalid ? b1.pdt_rerr : b1.if_rerr, cyc, e.port, e.data, e.err, e.due);
        end
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL w1_missing_resp cyc=%0d required rvalid port=%0b at cyc=%0d",
               cyc, q1[0].port, q1[0].due);
      void'(q1.pop_front());
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (b3.if_rvalid || b3.pdt_rvalid) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL w3_unexpected_resp if_rv=%0b pdt_rv=%0b cyc=%0d required none",
                 b3.if_rvalid, b3.pdt_rvalid, cyc);
      end else begin
        e = q3.pop_front();
        if (b3.pdt_rvalid !== e.port || b3.if_rvalid === b3.pdt_rvalid ||
            (e.port ? b3.pdt_rdata : b3.if_rdata) !== e.data ||
            (e.port ? b3.pdt_rerr : b3.if_rerr) !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL w3_resp port=%0b data=%h err=%0b cyc=%0d required port=%0b data=%h err=%0b cyc=%0d",
                   b3.pdt_rvalid, b3.pdt_rvalid ? b3.pdt_rdata : b3.if_rdata,
                   b3.pdt_rvalid ? b3.pdt_rerr : b3.if_rerr, cyc, e.port, e.data, e.err, e.due);
        end
      end
    end else if (q3.size() != 0 && q3[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL w3_missing_resp cyc=%0d required rvalid port=%0b at cyc=%0d",
               cyc, q3[0].port, q3[0].due);
      void'(q3.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({b1.if_gnt, b1.pdt_gnt, b1.if_rvalid, b1.pdt_rvalid, b1.if_rerr,
         b1.pdt_rerr, b1.rom_ce, busy1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl_w1 got=%b required 00000000",
               {b1.if_gnt, b1.pdt_gnt, b1.if_rvalid, b1.pdt_rvalid, b1.if_rerr,
                b1.pdt_rerr, b1.rom_ce, busy1});
    end
    checks++;
    if ({b1.if_rdata, b1.pdt_rdata, b1.rom_addr} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data_w1 if_rdata=%h pdt_rdata=%h rom_addr=%h required 0",
               b1.if_rdata, b1.pdt_rdata, b1.rom_addr);
    end
    checks++;
    if ({b3.rom_ce, busy3, b3.if_rvalid, b3.pdt_rvalid, b3.rom_addr} !== 36'h0) begin
      errors++;
      $display("FAIL reset_w3 rom_ce=%0b busy=%0b rom_addr=%h required 0",
               b3.rom_ce, busy3, b3.rom_addr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    b1.if_addr = 32'h4;
    b1.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({b1.if_gnt, b1.pdt_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_gnt got if=%0b pdt=%0b required if=1 pdt=0", b1.if_gnt, b1.pdt_gnt);
    end
    q1.push_back('{1'b0, 32'h3401_0020, 1'b0, cyc + 2});
    tick();
    b1.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.rom_ce !== 1'b1 || b1.rom_addr !== 32'h4 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rom rom_ce=%0b rom_addr=%h busy=%0b required 1 00000004 1",
               b1.rom_ce, b1.rom_addr, busy1);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== 32'h3401_0020) begin
      errors++;
      $display("FAIL fetch_resp rvalid=%0b rdata=%h required 1 34010020", b1.if_rvalid, b1.if_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b1.if_rvalid !== 1'b0 || b1.rom_ce !== 1'b0 || b1.rom_addr !== 32'h4 ||
        b1.if_rdata !== 32'h3401_0020) begin
      errors++;
      $display("FAIL fetch_after rvalid=%0b rom_ce=%0b rom_addr=%h rdata=%h required 0 0 00000004 34010020",
               b1.if_rvalid, b1.rom_ce, b1.rom_addr, b1.if_rdata);
    end
    tick();
  endtask

  task automatic test_misaligned();
    b1.if_addr = 32'h6;
    b1.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL misal_gnt got=%0b required 1", b1.if_gnt);
    end
    q1.push_back('{1'b0, 32'h0, 1'b1, cyc + 1});
    tick();
    b1.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.rom_ce !== 1'b0 || busy1 !== 1'b0 || b1.if_rvalid !== 1'b1 ||
        b1.if_rerr !== 1'b1 || b1.if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL misal_resp rom_ce=%0b busy=%0b rvalid=%0b rerr=%0b rdata=%h required 0 0 1 1 0",
               b1.rom_ce, busy1, b1.if_rvalid, b1.if_rerr, b1.if_rdata);
    end
    tick();
    b1.if_addr = 32'hC;
    b1.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL realign_gnt got=%0b required 1", b1.if_gnt);
    end
    q1.push_back('{1'b0, rom_word(32'hC), 1'b0, cyc + 2});
    tick();
    b1.if_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (b1.if_rerr !== 1'b0) begin
      errors++;
      $display("FAIL realign_rerr got=%0b required 0", b1.if_rerr);
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic exp_order [8];
    int n    = 0;
    int last = -1;
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    b1.if_addr  = 32'h8;
    b1.pdt_addr = 32'h20;
    b1.if_req   = 1'b1;
    b1.pdt_req  = 1'b1;
    for (int k = 0; k < 40 && n < 8; k++) begin
      @(negedge clk);
      checks++;
      if (b1.if_gnt && b1.pdt_gnt) begin
        errors++;
        $display("FAIL arb_double_gnt cyc=%0d required at most one gnt", cyc);
      end
      if (b1.if_gnt || b1.pdt_gnt) begin
        checks++;
        if (b1.pdt_gnt !== exp_order[n]) begin
          errors++;
          $display("FAIL arb_order grant=%0d got pdt=%0b required pdt=%0b", n, b1.pdt_gnt, exp_order[n]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 2) begin
            errors++;
            $display("FAIL arb_spacing grant=%0d gap=%0d required 2", n, cyc - last);
          end
        end
        q1.push_back('{exp_order[n], rom_word(exp_order[n] ? 32'h20 : 32'h8), 1'b0, cyc + 2});
        last = cyc;
        n++;
      end
      tick();
    end
    b1.if_req  = 1'b0;
    b1.pdt_req = 1'b0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL arb_timeout grants=%0d required 8", n);
    end
    repeat (3) tick();
  endtask

  task automatic test_pdt_only();
    b3.pdt_addr = 32'h10;
    b3.pdt_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({b3.if_gnt, b3.pdt_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL pdt_gnt got if=%0b pdt=%0b required if=0 pdt=1", b3.if_gnt, b3.pdt_gnt);
    end
    q3.push_back('{1'b1, rom_word(32'h10), 1'b0, cyc + 4});
    tick();
    b3.pdt_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy3 !== 1'b1 || b3.rom_ce !== 1'b1 || b3.rom_addr !== 32'h10) begin
        errors++;
        $display("FAIL pdt_busy cycle=%0d busy=%0b rom_ce=%0b rom_addr=%h required 1 1 00000010",
                 i, busy3, b3.rom_ce, b3.rom_addr);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (busy3 !== 1'b0 || b3.pdt_rvalid !== 1'b1 || b3.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL pdt_resp busy=%0b pdt_rvalid=%0b if_rvalid=%0b required 0 1 0",
               busy3, b3.pdt_rvalid, b3.if_rvalid);
    end
    tick();
  endtask

  task automatic test_flush();
    // Flush during BUSY cancels the IF response; pdt overlaps normally.
    b1.if_addr = 32'h14;
    b1.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_gnt got=%0b required 1", b1.if_gnt);
    end
    tick();
    b1.if_req   = 1'b0;
    b1.if_flush = 1'b1;
    tick();
    b1.if_flush = 1'b0;
    b1.pdt_addr = 32'h18;
    b1.pdt_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.if_rvalid !== 1'b0 || b1.pdt_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_cancel if_rvalid=%0b pdt_gnt=%0b required 0 1", b1.if_rvalid, b1.pdt_gnt);
    end
    q1.push_back('{1'b1, rom_word(32'h18), 1'b0, cyc + 2});
    tick();
    b1.pdt_req = 1'b0;
    repeat (3) tick();
    // Flush in IDLE coincident with a new IF grant leaves that grant intact.
    b1.if_addr  = 32'h1C;
    b1.if_req   = 1'b1;
    b1.if_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_coinc_gnt got=%0b required 1", b1.if_gnt);
    end
    q1.push_back('{1'b0, rom_word(32'h1C), 1'b0, cyc + 2});
    tick();
    b1.if_req   = 1'b0;
    b1.if_flush = 1'b0;
    repeat (3) tick();
    // Flush landing in the RESP cycle itself suppresses that strobe.
    b1.if_addr = 32'h4;
    b1.if_req  = 1'b1;
    tick();
    b1.if_req = 1'b0;
    tick();
    b1.if_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_resp if_rvalid=%0b required 0", b1.if_rvalid);
    end
    tick();
    b1.if_flush = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_abort();
    b3.if_addr = 32'h24;
    b3.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (b3.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_gnt got=%0b required 1", b3.if_gnt);
    end
    tick();
    b3.if_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({b3.rom_ce, busy3, b3.if_rvalid, b3.pdt_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_drop rom_ce=%0b busy=%0b if_rv=%0b pdt_rv=%0b required 0",
               b3.rom_ce, busy3, b3.if_rvalid, b3.pdt_rvalid);
    end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    b3.if_addr = 32'h28;
    b3.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (b3.if_gnt !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL abort_regnt gnt=%0b busy=%0b required 1 0", b3.if_gnt, busy3);
    end
    q3.push_back('{1'b0, rom_word(32'h28), 1'b0, cyc + 4});
    tick();
    b3.if_req = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    b1.if_req = 1'b0; b1.if_addr = '0; b1.if_flush = 1'b0; b1.pdt_req = 1'b0; b1.pdt_addr = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.if_flush = 1'b0; b3.pdt_req = 1'b0; b3.pdt_addr = '0;
    test_reset();
    test_single_fetch();
    test_misaligned();
    test_arbitration();
    test_pdt_only();
    test_flush();
    test_reset_abort();
    for (int k = 0; k < 20 && (q1.size() != 0 || q3.size() != 0); k++) tick();
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain pending w1=%0d w3=%0d required 0 0", q1.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
